// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index 0 is the pattern for digit "0".
    localparam logic [9:0][6:0] SEG_LUT = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Non-decimal nibbles are never produced by the converter; show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        if (nibble <= 4'd9) seg = SEG_LUT[nibble];
        else                seg = SEG_BLANK;
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble).
// Ports:
//   clk, rst    clock, synchronous active-high reset (aborts a conversion)
//   start       load value; honoured in IDLE and DONE
//   value       binary value to convert
//   busy        high in SHIFT and DONE
//   done        one-cycle pulse while bcd/ovf hold the finished result
//   bcd         low NUM_DIGITS BCD nibbles of the result
//   ovf         result does not fit in NUM_DIGITS decimal digits
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    ovf
);

    localparam int NIB   = NUM_DIGITS + 1;
    localparam int BCD_W = NIB * 4;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    conv_state_t        state;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [VALUE_W-1:0] bin_q;
    logic               spill_q;

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NIB; k++) begin
            if (bcd_q[k*4 +: 4] >= 4'd5)
                bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        spill_q <= 1'b0;
                        cnt_q   <= '0;
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                    // A bit pushed out of the guard nibble means the value is
                    // far beyond range; remember it so overflow stays visible.
                    spill_q <= spill_q | bcd_adj[BCD_W-1];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VALUE_W - 1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = bcd_q[NUM_DIGITS*4-1:0];
    assign ovf  = spill_q | (|bcd_q[BCD_W-1 -: 4]);

endmodule

// File: rtl/multi_digit_display.sv
// N-digit multiplexed common-anode 7-segment driver with sequential BCD
// conversion, leading-zero blanking, decimal points and overflow dashes.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   value        unsigned binary value, sampled when value_valid=1
//   value_valid  load strobe (buffered one deep while converting)
//   blank_lz     blank leading zeros (digit 0 always shown)
//   dp_mask      per-digit decimal point enable, sampled live
//   busy         conversion in progress
//   segments     {g,f,e,d,c,b,a}, active low
//   dp           decimal point, active low
//   digit_sel    digit enable, active low, bit 0 = least significant digit
module multi_digit_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  value_valid,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic                    conv_busy;
    logic                    conv_done;
    logic                    conv_start;
    logic [VALUE_W-1:0]      conv_value;
    logic [NUM_DIGITS*4-1:0] conv_bcd;
    logic                    conv_ovf;

    logic                    pend_full;
    logic [VALUE_W-1:0]      pend_val;

    logic [NUM_DIGITS*4-1:0] disp_q;
    logic                    ovf_q;

    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    tick;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              nib_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    // The converter accepts a new load in DONE as well, so a pending value
    // follows back-to-back without a busy gap. Pending always goes first.
    assign conv_start = (!conv_busy || conv_done) &&
                        (pend_full || (value_valid && !conv_busy));
    assign conv_value = pend_full ? pend_val : value;
    assign busy       = conv_busy;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (conv_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // One-deep pending buffer, last writer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
        end else if (conv_start && pend_full) begin
            pend_full <= value_valid;
        end else if (value_valid && conv_busy) begin
            pend_full <= 1'b1;
        end
        if (value_valid && (conv_busy || pend_full))
            pend_val <= value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end
    end

    // Decode for the digit about to be selected so that digit_sel, segments
    // and dp all change on the same edge.
    always_comb begin
        logic upper_zero;
        tick    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        upper_zero = 1'b1;
        lz         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_q[i*4 +: 4] == 4'd0);
            lz[i]      = upper_zero;
        end

        nib_nxt = disp_q[idx_nxt*4 +: 4];
        if (ovf_q) begin
            seg_nxt = SEG_DASH;
            dp_nxt  = 1'b1;
        end else if (blank_lz && (idx_nxt != '0) && lz[idx_nxt]) begin
            seg_nxt = SEG_BLANK;
            dp_nxt  = ~dp_mask[idx_nxt];
        end else begin
            seg_nxt = seg_decode(nib_nxt);
            dp_nxt  = ~dp_mask[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx_q     <= '0;
            segments  <= SEG_BLANK;
            dp        <= 1'b1;
            digit_sel <= '1;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
                idx_q     <= idx_nxt;
                digit_sel <= ~(NUM_DIGITS'(1) << idx_nxt);
                segments  <= seg_nxt;
                dp        <= dp_nxt;
            end
        end
    end

endmodule
